conv_sa_block_ctrl: RTL and testbench

- Sequencer for one systolic-array block: 8 PE rows followed by one sum row.
- Walks a job of n_rnd rounds × n_tile tiles, each tile being a K-element dot product.
- Per row, generates skewed reset/flush flags; for the sum row, generates psum valid, last-round, write-address and prefetch-address strobes.
- Tells the upstream x/w feeders when row 0 consumes data, and signals job done.

---
 rtl/conv_sa_block_ctrl_if.sv | 43 ++++
 rtl/conv_sa_block_ctrl.sv | 141 ++++++++++++++
 tb/tb_conv_sa_block_ctrl.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/conv_sa_block_ctrl_if.sv
// Control bundle between the systolic-array block sequencer and its
// job source, x/w feeders and the PE/sum rows it drives.
interface conv_sa_block_ctrl_if #(
  parameter int K_W   = 16,
  parameter int RND_W = 8
);
  logic             start;
  logic [K_W-1:0]   cfg_k;
  logic [3:0]       cfg_n_tile;
  logic [RND_W-1:0] cfg_n_rnd;
  logic             busy;
  logic             done;
  logic             feed_vld;
  logic             feed_first;
  logic             feed_last;
  logic [7:0]       out_rst;
  logic [7:0]       out_flush;
  logic             out_psum_vld;
  logic             out_psum_last_rnd;
  logic [2:0]       out_psum_wr_addr;
  logic [2:0]       out_psum_prefetch_addr;
  logic [7:0]       dbg_begin;
  logic [7:0]       dbg_end;
  logic [7:0]       dbg_rst;

  modport master (
    input  start, cfg_k, cfg_n_tile, cfg_n_rnd,
    output busy, done, feed_vld, feed_first, feed_last,
    output out_rst, out_flush,
    output out_psum_vld, out_psum_last_rnd,
    output out_psum_wr_addr, out_psum_prefetch_addr,
    output dbg_begin, dbg_end, dbg_rst
  );

  modport slave (
    output start, cfg_k, cfg_n_tile, cfg_n_rnd,
    input  busy, done, feed_vld, feed_first, feed_last,
    input  out_rst, out_flush,
    input  out_psum_vld, out_psum_last_rnd,
    input  out_psum_wr_addr, out_psum_prefetch_addr,
    input  dbg_begin, dbg_end, dbg_rst
  );
endinterface

// File: rtl/conv_sa_block_ctrl.sv
// Sequencer for one systolic-array block: 8 skewed PE rows plus a sum row.
// Walks rounds x tiles of K-element dot products and strobes psum writes.
module conv_sa_block_ctrl #(
  parameter int K_W   = 16,
  parameter int RND_W = 8
) (
  input  logic clk,
  input  logic rstn,
  conv_sa_block_ctrl_if.master io
);
  typedef enum logic [2:0] {
    S_IDLE, S_RST, S_MAC, S_DRAIN, S_DONE
  } state_t;

  state_t st, nxt;

  logic [K_W-1:0]   k_q, el;
  logic [3:0]       nt_q;
  logic [RND_W-1:0] nr_q, rnd;
  logic [2:0]       tile;
  logic             busy_q;
  logic [7:0]       fl;
  logic [7:1]       rsd, bgd, edd;
  logic [2:0]       sl [8];
  logic [7:0]       lr;
  logic             pv, plr;
  logic [2:0]       pwa, ppa;

  logic accept, bad, mac, rst0, first0;
  logic el_last, mac_last, tile_end, rnd_end;

  assign accept   = (st == S_IDLE) && io.start;
  assign bad      = (io.cfg_k == '0) || (io.cfg_n_tile == 4'd0) ||
                    (io.cfg_n_tile > 4'd8) || (io.cfg_n_rnd == '0);
  assign mac      = (st == S_MAC);
  assign rst0     = (st == S_RST);
  assign el_last  = (el == k_q - K_W'(1));
  assign mac_last = mac && el_last;
  assign first0   = mac && (el == '0);
  assign tile_end = ({1'b0, tile} == nt_q - 4'd1);
  assign rnd_end  = (rnd == nr_q - RND_W'(1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) st <= S_IDLE;
    else       st <= nxt;
  end

  always_comb begin
    nxt = st;
    unique case (st)
      S_IDLE:  if (io.start) nxt = bad ? S_DONE : S_RST;
      S_RST:   nxt = S_MAC;
      S_MAC:   if (el_last)
                 nxt = (tile_end && rnd_end) ? S_DRAIN : S_RST;
      S_DRAIN: if (fl == '0) nxt = S_DONE;
      S_DONE:  nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      k_q    <= '0;
      nt_q   <= '0;
      nr_q   <= '0;
      el     <= '0;
      tile   <= '0;
      rnd    <= '0;
      busy_q <= 1'b0;
    end else begin
      if (accept) begin
        k_q  <= io.cfg_k;
        nt_q <= io.cfg_n_tile;
        nr_q <= io.cfg_n_rnd;
        el   <= '0;
        tile <= '0;
        rnd  <= '0;
      end else if (mac) begin
        el <= el_last ? '0 : el + K_W'(1);
        if (el_last) begin
          if (tile_end) begin
            tile <= '0;
            rnd  <= rnd + RND_W'(1);
          end else begin
            tile <= tile + 3'd1;
          end
        end
      end
      // An invalid job enters DONE straight from IDLE, so busy shows for one cycle
      if (st == S_DONE || (st == S_DRAIN && nxt == S_DONE))
        busy_q <= 1'b0;
      else if (accept)
        busy_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fl  <= '0;
      rsd <= '0;
      bgd <= '0;
      edd <= '0;
      lr  <= '0;
      pv  <= 1'b0;
      plr <= 1'b0;
      pwa <= '0;
      ppa <= '0;
      for (int i = 0; i < 8; i++) sl[i] <= '0;
    end else begin
      fl  <= {fl[6:0], mac_last};
      rsd <= {rsd[6:1], rst0};
      bgd <= {bgd[6:1], first0};
      edd <= {edd[6:1], mac_last};
      // Slot/round metadata rides alongside the flush bit it belongs to
      sl[0] <= tile;
      lr    <= {lr[6:0], rnd_end};
      for (int i = 1; i < 8; i++) sl[i] <= sl[i-1];
      pv <= fl[7];
      if (fl[7]) begin
        pwa <= sl[7];
        plr <= lr[7];
      end
      if (fl[6]) ppa <= sl[6];
    end
  end

  assign io.busy                   = busy_q;
  assign io.done                   = (st == S_DONE);
  assign io.feed_vld               = mac;
  assign io.feed_first             = first0;
  assign io.feed_last              = mac_last;
  assign io.out_rst                = {rsd, rst0};
  assign io.out_flush              = fl;
  assign io.out_psum_vld           = pv;
  assign io.out_psum_last_rnd      = plr;
  assign io.out_psum_wr_addr       = pwa;
  assign io.out_psum_prefetch_addr = ppa;
  assign io.dbg_rst                = {rsd, rst0};
  assign io.dbg_begin              = {bgd, first0};
  assign io.dbg_end                = {edd, mac_last};
endmodule

// File: tb/tb_conv_sa_block_ctrl.sv
// Self-checking bench: closed-form timeline model per cycle plus a
// psum scoreboard filled at job start and drained as pulses appear.
module tb_conv_sa_block_ctrl;
  logic clk = 1'b0;
  logic rstn;

  always #5 clk = ~clk;

  conv_sa_block_ctrl_if #(.K_W(16), .RND_W(8)) bus ();

  conv_sa_block_ctrl #(.K_W(16), .RND_W(8)) dut (
    .clk  (clk),
    .rstn (rstn),
    .io   (bus.master)
  );

  typedef struct {
    int t;
    int addr;
    int last;
  } ev_t;

  ev_t q[$];
  int  n_chk = 0;
  int  n_err = 0;
  int  cur_t = 0;
  int  gk, gnt, gnr;
  bit  gvalid;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s t=%0d got=%0h exp=%0h", tag, cur_t, got, exp);
    end
  endtask

  function automatic bit e_rst(int t);
    int p = gk + 1;
    int tt = gnt * gnr;
    return gvalid && t >= 1 && t <= 1 + (tt - 1) * p && (t - 1) % p == 0;
  endfunction

  function automatic bit e_fl(int t);
    int p = gk + 1;
    int tt = gnt * gnr;
    return gvalid && t >= 1 + p && t <= 1 + tt * p && (t - 1) % p == 0;
  endfunction

  function automatic bit e_mac(int t);
    int p = gk + 1;
    int tt = gnt * gnr;
    return gvalid && t >= 2 && t <= tt * p && (t - 1) % p != 0;
  endfunction

  function automatic bit e_first(int t);
    return e_mac(t) && (t - 1) % (gk + 1) == 1 % (gk + 1);
  endfunction

  function automatic bit e_last(int t);
    return e_mac(t) && t % (gk + 1) == 0;
  endfunction

  task automatic chk_zero(string tag);
    chk({tag, "_vec"},
        {bus.out_rst, bus.out_flush, bus.dbg_begin, bus.dbg_end}, 0);
    chk({tag, "_dbgrst"}, {24'd0, bus.dbg_rst}, 0);
    chk({tag, "_ctl"},
        {27'd0, bus.busy, bus.done, bus.feed_vld,
         bus.feed_first, bus.feed_last}, 0);
    chk({tag, "_psum"},
        {24'd0, bus.out_psum_vld, bus.out_psum_last_rnd,
         bus.out_psum_wr_addr, bus.out_psum_prefetch_addr}, 0);
  endtask

  task automatic cycle_checks(int t, int td);
    logic [7:0] vr, vf, vb, ve;
    ev_t e;
    for (int i = 0; i < 8; i++) begin
      vr[i] = e_rst(t - i);
      vf[i] = e_fl(t - i);
      vb[i] = e_first(t - i);
      ve[i] = e_last(t - i);
    end
    chk("busy", {31'd0, bus.busy},
        {31'd0, gvalid ? (t >= 1 && t < td) : (t == 1)});
    chk("done", {31'd0, bus.done}, {31'd0, t == td});
    chk("feed_vld", {31'd0, bus.feed_vld}, {31'd0, e_mac(t)});
    chk("feed_first", {31'd0, bus.feed_first}, {31'd0, e_first(t)});
    chk("feed_last", {31'd0, bus.feed_last}, {31'd0, e_last(t)});
    chk("out_rst", {24'd0, bus.out_rst}, {24'd0, vr});
    chk("out_flush", {24'd0, bus.out_flush}, {24'd0, vf});
    chk("dbg_rst", {24'd0, bus.dbg_rst}, {24'd0, vr});
    chk("dbg_begin", {24'd0, bus.dbg_begin}, {24'd0, vb});
    chk("dbg_end", {24'd0, bus.dbg_end}, {24'd0, ve});
    if (q.size() > 0 && q[0].t == t + 1)
      chk("prefetch", {29'd0, bus.out_psum_prefetch_addr}, q[0].addr);
    if (bus.out_psum_vld) begin
      if (q.size() == 0) begin
        chk("psum_extra", 1, 0);
      end else begin
        e = q.pop_front();
        chk("psum_t", t, e.t);
        chk("psum_addr", {29'd0, bus.out_psum_wr_addr}, e.addr);
        chk("psum_last", {31'd0, bus.out_psum_last_rnd}, e.last);
      end
    end else if (q.size() > 0 && q[0].t <= t) begin
      chk("psum_miss", 0, q[0].t);
      void'(q.pop_front());
    end
  endtask

  task automatic run_job(int k, int nt, int nr, int stray, int abort_t);
    int td;
    int p;
    ev_t e;
    gk = k;
    gnt = nt;
    gnr = nr;
    gvalid = k > 0 && nt > 0 && nt <= 8 && nr > 0;
    p = k + 1;
    td = gvalid ? 10 + nt * nr * p : 1;
    q.delete();
    if (gvalid)
      for (int r = 0; r < nr; r++)
        for (int s = 0; s < nt; s++) begin
          e.t = 1 + (r * nt + s + 1) * p + 8;
          e.addr = s;
          e.last = (r == nr - 1) ? 1 : 0;
          q.push_back(e);
        end
    @(negedge clk);
    cur_t = 0;
    bus.cfg_k = 16'(k);
    bus.cfg_n_tile = 4'(nt);
    bus.cfg_n_rnd = 8'(nr);
    bus.start = 1'b1;
    for (int t = 1; t <= td + 2; t++) begin
      @(negedge clk);
      cur_t = t;
      cycle_checks(t, td);
      if (t == abort_t) begin
        rstn = 1'b0;
        #1;
        chk_zero("abort");
        q.delete();
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        chk_zero("in_reset");
        rstn = 1'b1;
        repeat (3) begin
          @(negedge clk);
          chk_zero("post_reset");
        end
        return;
      end
      bus.start = (t == stray);
      bus.cfg_k = 16'($urandom);
      bus.cfg_n_tile = 4'($urandom);
      bus.cfg_n_rnd = 8'($urandom);
    end
    chk("sb_empty", q.size(), 0);
  endtask

  initial begin
    rstn = 1'b0;
    bus.start = 1'b0;
    bus.cfg_k = '0;
    bus.cfg_n_tile = '0;
    bus.cfg_n_rnd = '0;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rstn = 1'b1;
    @(negedge clk);
    chk_zero("idle");

    run_job(4, 2, 2, 5, -1);
    run_job(1, 8, 1, -1, -1);
    run_job(4, 0, 2, -1, -1);
    run_job(4, 2, 0, -1, -1);
    run_job(4, 9, 1, -1, -1);
    run_job(0, 2, 1, -1, -1);
    run_job(4, 2, 2, -1, 10);
    run_job(4, 2, 2, -1, -1);
    run_job(3, 3, 2, 7, -1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
